// File: rtl/rvh_l1d_lsu_resp_queue.sv
// L1D load-response stage: selects load data from STB bypass, refill line or
// tag-hit way, formats it by size/sign, classifies it as an integer writeback
// or a PTW response, and buffers it in an in-order FIFO with valid/ready
// hand-off so that consumer back-pressure never stalls the bank pipe.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush_i               drop all queued entries and the same-cycle input
//   in_valid_i/in_ready_o response candidate handshake
//   refill_valid_i, tag_hit_way_i, tlb_hit_i, line_dat_i, offset_i,
//   size_i, unsigned_i    data source selection and formatting controls
//   is_load_i, is_ptw_i, is_raw_i, is_nodata_wb_i  request class
//   rob_tag_i, prd_i      destination tags
//   stb_bypass_valid_i/stb_bypass_data_i  store-buffer forwarded data
//   wb_*                  PRF/ROB writeback port (valid/ready)
//   ptw_*                 page-table-walker response port (valid/ready)
//   count_o               FIFO occupancy
module rvh_l1d_lsu_resp_queue #(
    parameter int unsigned WAY_NUM    = 4,
    parameter int unsigned XLEN       = 64,
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned SEG_BYTES  = 16,
    parameter int unsigned ROB_TAG_W  = 4,
    parameter int unsigned PREG_TAG_W = 6,
    parameter int unsigned PTW_ID_W   = 1,
    parameter int unsigned QDEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          refill_valid_i,
    input  logic [WAY_NUM-1:0]            tag_hit_way_i,
    input  logic                          tlb_hit_i,
    input  logic [LINE_BYTES*8-1:0]       line_dat_i,
    input  logic [$clog2(LINE_BYTES)-1:0] offset_i,
    input  logic [1:0]                    size_i,
    input  logic                          unsigned_i,
    input  logic                          is_load_i,
    input  logic                          is_ptw_i,
    input  logic                          is_raw_i,
    input  logic                          is_nodata_wb_i,
    input  logic [ROB_TAG_W-1:0]          rob_tag_i,
    input  logic [PREG_TAG_W-1:0]         prd_i,
    input  logic                          stb_bypass_valid_i,
    input  logic [XLEN-1:0]               stb_bypass_data_i,
    output logic                          wb_valid_o,
    input  logic                          wb_ready_i,
    output logic [ROB_TAG_W-1:0]          wb_rob_tag_o,
    output logic [PREG_TAG_W-1:0]         wb_prd_o,
    output logic [XLEN-1:0]               wb_data_o,
    output logic                          wb_from_mlfb_o,
    output logic                          ptw_valid_o,
    input  logic                          ptw_ready_i,
    output logic [PTW_ID_W-1:0]           ptw_id_o,
    output logic [XLEN-1:0]               ptw_pte_o,
    output logic [$clog2(QDEPTH):0]       count_o
);

    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam int unsigned SEG_W  = SEG_BYTES * 8;
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned PTR_W  = $clog2(QDEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic                  ptw;
        logic                  mlfb;
        logic [ROB_TAG_W-1:0]  rob_tag;
        logic [PREG_TAG_W-1:0] prd;
        logic [XLEN-1:0]       data;
    } entry_t;

    entry_t            mem_q [QDEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    logic [XLEN-1:0]        refill_word;
    logic [LINE_W+XLEN-1:0] refill_ext;
    logic [OFF_W-1:0]       word_idx;
    logic [XLEN-1:0]        way_word [WAY_NUM];
    logic [XLEN-1:0]        hit_word;
    logic [XLEN-1:0]        sel_data;
    logic [XLEN-1:0]        fmt_data;
    logic                   cls_int, cls_ptw;
    logic                   enq, deq, head_v;
    entry_t                 enq_entry, head;

    // Refill source: line zero-extended above its top so high offsets fill zeros
    assign refill_ext  = {{XLEN{1'b0}}, line_dat_i};
    assign refill_word = XLEN'(refill_ext >> {offset_i, 3'b000});

    // XLEN-word index inside a way segment
    assign word_idx = (offset_i >> 3) & OFF_W'(SEG_BYTES / 8 - 1);

    // Per-way aligned data from that way's segment of the hit bus
    for (genvar w = 0; w < WAY_NUM; w++) begin : g_way
        logic [SEG_W-1:0] seg;
        assign seg         = line_dat_i[w*SEG_W +: SEG_W];
        assign way_word[w] = XLEN'(seg >> (32'(word_idx) * XLEN)) >> {offset_i[2:0], 3'b000};
    end

    // AND-OR way select; no hit yields zero, multi-hot ORs the ways
    always_comb begin
        hit_word = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (tag_hit_way_i[w]) hit_word = hit_word | way_word[w];
        end
    end

    // Source priority: STB bypass > refill > tag hit
    always_comb begin
        sel_data = hit_word;
        if (stb_bypass_valid_i)  sel_data = stb_bypass_data_i;
        else if (refill_valid_i) sel_data = refill_word;
    end

    // Size mask and sign extension (dword is never extended)
    always_comb begin
        fmt_data = sel_data;
        case (size_i)
            2'd0: fmt_data = {{(XLEN-8){sel_data[7] & ~unsigned_i}}, sel_data[7:0]};
            2'd1: fmt_data = {{(XLEN-16){sel_data[15] & ~unsigned_i}}, sel_data[15:0]};
            2'd2: fmt_data = {{(XLEN-32){sel_data[31] & ~unsigned_i}}, sel_data[31:0]};
            default: fmt_data = sel_data;
        endcase
    end

    // Classification; anything neither PTW nor INT is accepted and dropped
    assign cls_ptw = is_ptw_i;
    assign cls_int = ~is_ptw_i &
                     ((is_load_i & (tlb_hit_i | refill_valid_i | stb_bypass_valid_i)) |
                      is_raw_i | is_nodata_wb_i);

    always_comb begin
        enq_entry         = '0;
        enq_entry.ptw     = cls_ptw;
        enq_entry.mlfb    = is_load_i & refill_valid_i & ~stb_bypass_valid_i;
        enq_entry.rob_tag = rob_tag_i;
        enq_entry.prd     = prd_i;
        if (cls_ptw)             enq_entry.data = sel_data;
        else if (is_nodata_wb_i) enq_entry.data = '0;
        else if (is_raw_i)       enq_entry.data = line_dat_i[XLEN-1:0];
        else                     enq_entry.data = fmt_data;
    end

    // Head dispatch: the class of the oldest entry decides which port is valid
    assign head           = mem_q[rptr_q];
    assign head_v         = (cnt_q != '0);
    assign in_ready_o     = (cnt_q < CNT_W'(QDEPTH));
    assign wb_valid_o     = head_v & ~head.ptw;
    assign ptw_valid_o    = head_v &  head.ptw;
    assign wb_rob_tag_o   = head.rob_tag;
    assign wb_prd_o       = head.prd;
    assign wb_data_o      = head.data;
    assign wb_from_mlfb_o = head.mlfb;
    assign ptw_id_o       = head.rob_tag[PTW_ID_W-1:0];
    assign ptw_pte_o      = head.data;
    assign count_o        = cnt_q;

    assign enq = in_valid_i & in_ready_o & (cls_int | cls_ptw) & ~flush_i;
    assign deq = ((wb_valid_o & wb_ready_i) | (ptw_valid_o & ptw_ready_i)) & ~flush_i;

    // Pointer/occupancy next state; flush wins over any handshake
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (enq) wptr_d = wptr_q + PTR_W'(1);
            if (deq) rptr_d = rptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Storage is cleared on reset so data outputs start at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (enq) mem_q[wptr_q] <= enq_entry;
        end
    end

endmodule

// File: tb/tb_rvh_l1d_lsu_resp_queue.sv
// Directed bench for rvh_l1d_lsu_resp_queue with default parameters.
module tb_rvh_l1d_lsu_resp_queue;

    logic         clk;
    logic         rst;
    logic         flush_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic         refill_valid_i;
    logic [3:0]   tag_hit_way_i;
    logic         tlb_hit_i;
    logic [511:0] line_dat_i;
    logic [5:0]   offset_i;
    logic [1:0]   size_i;
    logic         unsigned_i;
    logic         is_load_i;
    logic         is_ptw_i;
    logic         is_raw_i;
    logic         is_nodata_wb_i;
    logic [3:0]   rob_tag_i;
    logic [5:0]   prd_i;
    logic         stb_bypass_valid_i;
    logic [63:0]  stb_bypass_data_i;
    logic         wb_valid_o;
    logic         wb_ready_i;
    logic [3:0]   wb_rob_tag_o;
    logic [5:0]   wb_prd_o;
    logic [63:0]  wb_data_o;
    logic         wb_from_mlfb_o;
    logic         ptw_valid_o;
    logic         ptw_ready_i;
    logic [0:0]   ptw_id_o;
    logic [63:0]  ptw_pte_o;
    logic [2:0]   count_o;

    int n_checks;
    int n_fails;

    rvh_l1d_lsu_resp_queue dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush_i),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .refill_valid_i     (refill_valid_i),
        .tag_hit_way_i      (tag_hit_way_i),
        .tlb_hit_i          (tlb_hit_i),
        .line_dat_i         (line_dat_i),
        .offset_i           (offset_i),
        .size_i             (size_i),
        .unsigned_i         (unsigned_i),
        .is_load_i          (is_load_i),
        .is_ptw_i           (is_ptw_i),
        .is_raw_i           (is_raw_i),
        .is_nodata_wb_i     (is_nodata_wb_i),
        .rob_tag_i          (rob_tag_i),
        .prd_i              (prd_i),
        .stb_bypass_valid_i (stb_bypass_valid_i),
        .stb_bypass_data_i  (stb_bypass_data_i),
        .wb_valid_o         (wb_valid_o),
        .wb_ready_i         (wb_ready_i),
        .wb_rob_tag_o       (wb_rob_tag_o),
        .wb_prd_o           (wb_prd_o),
        .wb_data_o          (wb_data_o),
        .wb_from_mlfb_o     (wb_from_mlfb_o),
        .ptw_valid_o        (ptw_valid_o),
        .ptw_ready_i        (ptw_ready_i),
        .ptw_id_o           (ptw_id_o),
        .ptw_pte_o          (ptw_pte_o),
        .count_o            (count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request controls to idle; readies and line data are left alone
    task automatic idle();
        flush_i            = 1'b0;
        in_valid_i         = 1'b0;
        refill_valid_i     = 1'b0;
        tag_hit_way_i      = '0;
        tlb_hit_i          = 1'b0;
        offset_i           = '0;
        size_i             = '0;
        unsigned_i         = 1'b0;
        is_load_i          = 1'b0;
        is_ptw_i           = 1'b0;
        is_raw_i           = 1'b0;
        is_nodata_wb_i     = 1'b0;
        rob_tag_i          = '0;
        prd_i              = '0;
        stb_bypass_valid_i = 1'b0;
        stb_bypass_data_i  = '0;
    endtask

    // Tag-hit signed/unsigned load on way 2
    task automatic hit_load(input logic [5:0] off, input logic [1:0] sz, input logic uns,
                            input logic [3:0] hit, input logic [3:0] tag);
        idle();
        in_valid_i    = 1'b1;
        is_load_i     = 1'b1;
        tlb_hit_i     = 1'b1;
        tag_hit_way_i = hit;
        offset_i      = off;
        size_i        = sz;
        unsigned_i    = uns;
        rob_tag_i     = tag;
        prd_i         = 6'(tag) + 6'd32;
    endtask

    // INT entry carrying its tag as dword bypass data
    task automatic push_int(input logic [3:0] tag);
        idle();
        in_valid_i         = 1'b1;
        is_load_i          = 1'b1;
        stb_bypass_valid_i = 1'b1;
        stb_bypass_data_i  = 64'(tag);
        size_i             = 2'd3;
        rob_tag_i          = tag;
        prd_i              = 6'(tag);
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        line_dat_i  = '0;
        wb_ready_i  = 1'b1;
        ptw_ready_i = 1'b1;
        idle();
        rst = 1'b1;
        step();
        step();
        check("rst_count",    64'(count_o), 64'd0);
        check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        check("rst_ptw_valid",64'(ptw_valid_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_wb_data",  wb_data_o, 64'd0);
        check("rst_ptw_pte",  ptw_pte_o, 64'd0);
        rst = 1'b0;
        step();

        // Way 2: word0 / word1; way 1 word1 as a distractor
        line_dat_i[2*128      +: 64] = 64'h0123_4567_89AB_CDEF;
        line_dat_i[2*128 + 64 +: 64] = 64'h8877_6655_F4F3_F2F1;
        line_dat_i[1*128 + 64 +: 64] = 64'hAAAA_BBBB_CCCC_DDDD;

        hit_load(6'h1A, 2'd2, 1'b0, 4'b0100, 4'd1);
        step();
        check("hit_w_valid", 64'(wb_valid_o), 64'd1);
        check("hit_w_data",  wb_data_o, 64'h0000_0000_6655_F4F3);
        check("hit_w_mlfb",  64'(wb_from_mlfb_o), 64'd0);
        check("hit_w_tag",   64'(wb_rob_tag_o), 64'd1);
        check("hit_w_prd",   64'(wb_prd_o), 64'd33);

        hit_load(6'h18, 2'd2, 1'b0, 4'b0100, 4'd2);
        step();
        check("hit_wneg_count", 64'(count_o), 64'd1);
        check("hit_wneg_data",  wb_data_o, 64'hFFFF_FFFF_F4F3_F2F1);

        hit_load(6'h1F, 2'd0, 1'b0, 4'b0100, 4'd3);
        step();
        check("hit_b_data", wb_data_o, 64'hFFFF_FFFF_FFFF_FF88);

        hit_load(6'h1C, 2'd1, 1'b1, 4'b0100, 4'd4);
        step();
        check("hit_hu_data", wb_data_o, 64'h0000_0000_0000_6655);

        hit_load(6'h10, 2'd3, 1'b0, 4'b0100, 4'd5);
        step();
        check("hit_d_word0", wb_data_o, 64'h0123_4567_89AB_CDEF);

        hit_load(6'h18, 2'd3, 1'b0, 4'b0010, 4'd6);
        step();
        check("hit_way1", wb_data_o, 64'hAAAA_BBBB_CCCC_DDDD);

        hit_load(6'h18, 2'd3, 1'b0, 4'b0000, 4'd7);
        step();
        check("hit_none_valid", 64'(wb_valid_o), 64'd1);
        check("hit_none_data",  wb_data_o, 64'd0);

        // Line byte i holds value i
        for (int i = 0; i < 64; i++) line_dat_i[i*8 +: 8] = 8'(i);

        idle();
        in_valid_i = 1'b1; is_load_i = 1'b1; refill_valid_i = 1'b1;
        offset_i = 6'h3C; size_i = 2'd3; rob_tag_i = 4'd8;
        step();
        check("refill_hi_data", wb_data_o, 64'h0000_0000_3F3E_3D3C);
        check("refill_hi_mlfb", 64'(wb_from_mlfb_o), 64'd1);

        idle();
        in_valid_i = 1'b1; is_load_i = 1'b1; refill_valid_i = 1'b1;
        offset_i = 6'h00; size_i = 2'd3; rob_tag_i = 4'd9;
        step();
        check("refill_lo_data", wb_data_o, 64'h0706_0504_0302_0100);

        idle();
        in_valid_i = 1'b1; is_load_i = 1'b1; refill_valid_i = 1'b1;
        stb_bypass_valid_i = 1'b1; stb_bypass_data_i = 64'hABCD_1234;
        offset_i = 6'h3C; size_i = 2'd1; unsigned_i = 1'b1; rob_tag_i = 4'd10;
        step();
        check("stb_data", wb_data_o, 64'h0000_0000_0000_1234);
        check("stb_mlfb", 64'(wb_from_mlfb_o), 64'd0);

        idle();
        in_valid_i = 1'b1; is_raw_i = 1'b1; offset_i = 6'h3C; size_i = 2'd0;
        rob_tag_i = 4'd11;
        step();
        check("raw_data", wb_data_o, 64'h0706_0504_0302_0100);

        idle();
        in_valid_i = 1'b1; is_nodata_wb_i = 1'b1;
        stb_bypass_valid_i = 1'b1; stb_bypass_data_i = 64'h55;
        rob_tag_i = 4'd12;
        step();
        check("nodata_valid", 64'(wb_valid_o), 64'd1);
        check("nodata_data",  wb_data_o, 64'd0);

        idle();
        in_valid_i = 1'b1; is_ptw_i = 1'b1; refill_valid_i = 1'b1;
        offset_i = 6'h08; size_i = 2'd0; rob_tag_i = 4'd3;
        step();
        check("ptw_valid",    64'(ptw_valid_o), 64'd1);
        check("ptw_wb_valid", 64'(wb_valid_o), 64'd0);
        check("ptw_pte",      ptw_pte_o, 64'h0F0E_0D0C_0B0A_0908);
        check("ptw_id",       64'(ptw_id_o), 64'd1);
        idle();
        step();
        check("drain_count", 64'(count_o), 64'd0);

        // Back-pressure: fill, hold a fifth, then drain in order
        wb_ready_i = 1'b0;
        for (int t = 0; t < 4; t++) begin
            push_int(4'(t));
            step();
        end
        check("full_count",    64'(count_o), 64'd4);
        check("full_in_ready", 64'(in_ready_o), 64'd0);
        push_int(4'd4);
        step();
        check("full_hold_count", 64'(count_o), 64'd4);
        check("full_hold_head",  64'(wb_rob_tag_o), 64'd0);
        idle();
        wb_ready_i = 1'b1;
        for (int t = 0; t < 4; t++) begin
            check($sformatf("drain_tag%0d", t), 64'(wb_rob_tag_o), 64'(t));
            check($sformatf("drain_dat%0d", t), wb_data_o, 64'(t));
            step();
        end
        check("drain_empty", 64'(wb_valid_o), 64'd0);

        // Ordering: stalled PTW head blocks a younger INT entry
        ptw_ready_i = 1'b0;
        idle();
        in_valid_i = 1'b1; is_ptw_i = 1'b1; rob_tag_i = 4'd6;
        stb_bypass_valid_i = 1'b1; stb_bypass_data_i = 64'hCAFE;
        step();
        push_int(4'd7);
        step();
        idle();
        check("ord_count",     64'(count_o), 64'd2);
        check("ord_ptw_valid", 64'(ptw_valid_o), 64'd1);
        check("ord_wb_block",  64'(wb_valid_o), 64'd0);
        step();
        check("ord_wb_block2", 64'(wb_valid_o), 64'd0);
        check("ord_pte_hold",  ptw_pte_o, 64'hCAFE);
        ptw_ready_i = 1'b1;
        step();
        check("ord_ptw_gone", 64'(ptw_valid_o), 64'd0);
        check("ord_wb_now",   64'(wb_valid_o), 64'd1);
        check("ord_wb_tag",   64'(wb_rob_tag_o), 64'd7);
        step();
        check("ord_empty", 64'(count_o), 64'd0);

        // Flush with three queued entries and a valid same-cycle input
        wb_ready_i = 1'b0;
        for (int t = 0; t < 3; t++) begin
            push_int(4'(t + 1));
            step();
        end
        check("fl_pre_count", 64'(count_o), 64'd3);
        push_int(4'd9);
        flush_i = 1'b1;
        step();
        idle();
        check("fl_count",     64'(count_o), 64'd0);
        check("fl_wb_valid",  64'(wb_valid_o), 64'd0);
        check("fl_ptw_valid", 64'(ptw_valid_o), 64'd0);
        check("fl_in_ready",  64'(in_ready_o), 64'd1);

        // DROP class: TLB-miss load is accepted but never stored
        idle();
        in_valid_i = 1'b1; is_load_i = 1'b1; tlb_hit_i = 1'b0;
        tag_hit_way_i = 4'b0001; rob_tag_i = 4'd13;
        check("drop_ready", 64'(in_ready_o), 64'd1);
        step();
        idle();
        check("drop_count",     64'(count_o), 64'd0);
        check("drop_wb_valid",  64'(wb_valid_o), 64'd0);
        check("drop_ptw_valid", 64'(ptw_valid_o), 64'd0);

        // Pointers restart at zero after flush: one push then drain
        push_int(4'd14);
        step();
        idle();
        check("post_fl_tag", 64'(wb_rob_tag_o), 64'd14);
        wb_ready_i = 1'b1;
        step();
        check("post_fl_empty", 64'(count_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
